// File: rtl/rf_wb_if.sv
// Writeback request bundle: two valid/ready requesters (A, B)
// feeding the register-file write arbiter.
interface rf_wb_if #(
  parameter int XLEN = 32,
  parameter int AW   = 5
);
  logic            a_valid;
  logic            a_ready;
  logic [AW-1:0]   a_addr;
  logic [XLEN-1:0] a_data;
  logic            b_valid;
  logic            b_ready;
  logic [AW-1:0]   b_addr;
  logic [XLEN-1:0] b_data;

  modport master (
    output a_valid, a_addr, a_data,
    output b_valid, b_addr, b_data,
    input  a_ready, b_ready
  );

  modport slave (
    input  a_valid, a_addr, a_data,
    input  b_valid, b_addr, b_data,
    output a_ready, b_ready
  );
endinterface

// File: rtl/rf_wb_arbiter.sv
// Register-file write-port owner: zero-sweeps x1..x31 after reset,
// then round-robin arbitrates two writeback requesters.
module rf_wb_arbiter #(
  parameter int XLEN    = 32,
  parameter int AW      = 5,
  parameter int INIT_EN = 1
) (
  input  logic            clock,
  input  logic            reset,
  rf_wb_if.slave          wb,
  output logic            rf_we,
  output logic [AW-1:0]   rf_waddr,
  output logic [XLEN-1:0] rf_wdata,
  output logic            init_done,
  output logic            last_src
);

  localparam logic [0:0] S_INIT = 1'b0;
  localparam logic [0:0] S_RUN  = 1'b1;
  localparam logic [AW-1:0] A_LAST = '1;

  logic [0:0]      r_state;
  logic [AW-1:0]   r_cnt;
  logic            r_we;
  logic [AW-1:0]   r_waddr;
  logic [XLEN-1:0] r_wdata;
  logic            r_init_done;
  logic            r_last;

  logic w_live;
  logic w_gnt_a;
  logic w_gnt_b;

  // Ready is gated by reset so a beat offered during reset is never
  // seen as accepted by its requester.
  assign w_live  = (r_state == S_RUN) & r_init_done & ~reset;
  assign w_gnt_a = w_live & wb.a_valid & (~wb.b_valid | r_last);
  assign w_gnt_b = w_live & wb.b_valid & (~wb.a_valid | ~r_last);

  assign wb.a_ready = w_gnt_a;
  assign wb.b_ready = w_gnt_b;

  assign rf_we     = r_we;
  assign rf_waddr  = r_waddr;
  assign rf_wdata  = r_wdata;
  assign init_done = r_init_done;
  assign last_src  = r_last;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state     <= S_INIT;
      r_cnt       <= AW'(1);
      r_we        <= 1'b0;
      r_waddr     <= '0;
      r_wdata     <= '0;
      r_init_done <= 1'b0;
      r_last      <= 1'b1;
    end else begin
      unique case (r_state)
        S_INIT: begin
          if (INIT_EN != 0) begin
            r_we    <= 1'b1;
            r_waddr <= r_cnt;
            r_wdata <= '0;
            r_cnt   <= r_cnt + AW'(1);
            if (r_cnt == A_LAST)
              r_state <= S_RUN;
          end else begin
            r_state     <= S_RUN;
            r_init_done <= 1'b1;
          end
        end
        S_RUN: begin
          // First RUN edge closes out the sweep before granting.
          if (!r_init_done) begin
            r_init_done <= 1'b1;
            r_we        <= 1'b0;
          end else begin
            unique case (1'b1)
              w_gnt_a: begin
                r_we    <= (wb.a_addr != '0);
                r_waddr <= wb.a_addr;
                r_wdata <= wb.a_data;
                r_last  <= 1'b0;
              end
              w_gnt_b: begin
                r_we    <= (wb.b_addr != '0);
                r_waddr <= wb.b_addr;
                r_wdata <= wb.b_data;
                r_last  <= 1'b1;
              end
              default: r_we <= 1'b0;
            endcase
          end
        end
        default: r_state <= S_INIT;
      endcase
    end
  end

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Self-checking bench for rf_wb_arbiter: sweep, arbitration,
// x0 handling, collisions, random traffic and reset aborts.
module tb_rf_wb_arbiter;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        init_done;
  logic        last_src;

  rf_wb_if #(.XLEN(32), .AW(5)) wb ();

  rf_wb_arbiter #(.XLEN(32), .AW(5), .INIT_EN(1)) dut (
    .clock     (clock),
    .reset     (reset),
    .wb        (wb.slave),
    .rf_we     (rf_we),
    .rf_waddr  (rf_waddr),
    .rf_wdata  (rf_wdata),
    .init_done (init_done),
    .last_src  (last_src)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [4:0]  addr;
    logic [31:0] data;
  } beat_t;

  logic [31:0] rf_mem [32];
  logic        rf_scramble = 1'b0;

  // Register file that commits one edge after the write appears.
  always @(posedge clock) begin
    if (rf_scramble) begin
      for (int i = 0; i < 32; i++)
        rf_mem[i] <= 32'hA5A5_0000 | i;
    end else if (rf_we) begin
      rf_mem[rf_waddr] <= rf_wdata;
    end
  end

  int          n_checks = 0;
  int          n_fail   = 0;
  bit          m_last   = 1'b1;
  logic [31:0] exp_mem [32];
  bit          touched [32];
  logic [4:0]  grant_log [$];
  beat_t       qa [$];
  beat_t       qb [$];

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    wb.a_valid = 1'b0;
    wb.b_valid = 1'b0;
    wb.a_addr  = '0;
    wb.b_addr  = '0;
    wb.a_data  = '0;
    wb.b_data  = '0;
  endtask

  // Called right after reset is released; covers edges 1..32.
  task automatic sweep_check(input string tag);
    wb.a_valid = 1'b1;
    wb.b_valid = 1'b1;
    wb.a_addr  = 5'($urandom);
    wb.b_addr  = 5'($urandom);
    wb.a_data  = $urandom;
    wb.b_data  = $urandom;
    for (int k = 1; k <= 31; k++) begin
      step();
      n_checks++;
      if ({rf_we, rf_waddr, rf_wdata, init_done, wb.a_ready, wb.b_ready}
          !== {1'b1, 5'(k), 32'h0, 1'b0, 1'b0, 1'b0}) begin
        n_fail++;
        $display("FAIL %s edge %0d: we=%b addr=%0d data=%h done=%b ar=%b br=%b, want we=1 addr=%0d data=0 done=0 ar=0 br=0",
                 tag, k, rf_we, rf_waddr, rf_wdata, init_done,
                 wb.a_ready, wb.b_ready, k);
      end
    end
    idle_inputs();
    #1;
    n_checks++;
    if ({init_done, wb.a_ready, wb.b_ready} !== 3'b000) begin
      n_fail++;
      $display("FAIL %s pre-edge32: done=%b ar=%b br=%b, want 0 0 0",
               tag, init_done, wb.a_ready, wb.b_ready);
    end
    step();
    n_checks++;
    if ({init_done, rf_we} !== 2'b10) begin
      n_fail++;
      $display("FAIL %s edge 32: done=%b we=%b, want done=1 we=0",
               tag, init_done, rf_we);
    end
    m_last = 1'b1;
  endtask

  // Drives queued beats with optional idle gaps; reference model:
  // a lone pending beat wins, two pending beats go to the source
  // that did not win last.
  task automatic run_stream(input int idle_pct, input string tag);
    bit    a_on = 1'b0;
    bit    b_on = 1'b0;
    bit    ga, gb, src;
    int    a_wait = 0;
    int    b_wait = 0;
    int    cyc = 0;
    beat_t e;
    grant_log.delete();
    for (int i = 0; i < 32; i++) touched[i] = 1'b0;
    while ((qa.size() > 0 || qb.size() > 0) && cyc < 400) begin
      cyc++;
      if (!a_on && qa.size() > 0 && $urandom_range(99) >= idle_pct)
        a_on = 1'b1;
      if (!b_on && qb.size() > 0 && $urandom_range(99) >= idle_pct)
        b_on = 1'b1;
      wb.a_valid = a_on;
      wb.b_valid = b_on;
      wb.a_addr  = a_on ? qa[0].addr : 5'($urandom);
      wb.a_data  = a_on ? qa[0].data : $urandom;
      wb.b_addr  = b_on ? qb[0].addr : 5'($urandom);
      wb.b_data  = b_on ? qb[0].data : $urandom;
      #1;
      ga = a_on && (!b_on || m_last);
      gb = b_on && (!a_on || !m_last);
      n_checks++;
      if ({wb.a_ready, wb.b_ready} !== {ga, gb}) begin
        n_fail++;
        $display("FAIL %s ready cyc %0d: a_ready=%b b_ready=%b, want %b %b",
                 tag, cyc, wb.a_ready, wb.b_ready, ga, gb);
      end
      a_wait = (a_on && !ga) ? a_wait + 1 : 0;
      b_wait = (b_on && !gb) ? b_wait + 1 : 0;
      n_checks++;
      if (a_wait > 1 || b_wait > 1) begin
        n_fail++;
        $display("FAIL %s fairness cyc %0d: a_wait=%0d b_wait=%0d, want <=1",
                 tag, cyc, a_wait, b_wait);
      end
      src = 1'b0;
      if (ga) begin
        e = qa.pop_front();
        a_on = 1'b0;
        src = 1'b0;
      end else if (gb) begin
        e = qb.pop_front();
        b_on = 1'b0;
        src = 1'b1;
      end
      step();
      n_checks++;
      if (ga || gb) begin
        m_last = src;
        grant_log.push_back(e.addr);
        if (e.addr != 5'd0) begin
          exp_mem[e.addr] = e.data;
          touched[e.addr] = 1'b1;
        end
        if ({rf_we, rf_waddr, rf_wdata, last_src}
            !== {(e.addr != 5'd0), e.addr, e.data, src}) begin
          n_fail++;
          $display("FAIL %s write cyc %0d: we=%b addr=%0d data=%h last=%b, want we=%b addr=%0d data=%h last=%b",
                   tag, cyc, rf_we, rf_waddr, rf_wdata, last_src,
                   (e.addr != 5'd0), e.addr, e.data, src);
        end
      end else begin
        if ({rf_we, last_src} !== {1'b0, m_last}) begin
          n_fail++;
          $display("FAIL %s idle cyc %0d: we=%b last=%b, want we=0 last=%b",
                   tag, cyc, rf_we, last_src, m_last);
        end
      end
    end
    idle_inputs();
    n_checks++;
    if (qa.size() != 0 || qb.size() != 0) begin
      n_fail++;
      $display("FAIL %s timeout: %0d A and %0d B beats left, want 0",
               tag, qa.size(), qb.size());
      qa.delete();
      qb.delete();
    end
    step();
    n_checks++;
    if (rf_we !== 1'b0) begin
      n_fail++;
      $display("FAIL %s drain: we=%b, want 0", tag, rf_we);
    end
    for (int i = 1; i < 32; i++) begin
      if (touched[i]) begin
        n_checks++;
        if (rf_mem[i] !== exp_mem[i]) begin
          n_fail++;
          $display("FAIL %s final x%0d: got %h, want %h",
                   tag, i, rf_mem[i], exp_mem[i]);
        end
      end
    end
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1'b1;
    rf_scramble = 1'b1;
    repeat (3) step();
    rf_scramble = 1'b0;
    n_checks++;
    if ({rf_we, rf_waddr, rf_wdata, init_done, last_src}
        !== {1'b0, 5'd0, 32'h0, 1'b0, 1'b1}) begin
      n_fail++;
      $display("FAIL reset: we=%b addr=%0d data=%h done=%b last=%b, want 0 0 0 0 1",
               rf_we, rf_waddr, rf_wdata, init_done, last_src);
    end
    reset = 1'b0;
    sweep_check("sweep");
    for (int i = 1; i < 32; i++) begin
      n_checks++;
      if (rf_mem[i] !== 32'h0) begin
        n_fail++;
        $display("FAIL readback x%0d: got %h, want 0", i, rf_mem[i]);
      end
    end
    n_checks++;
    if (rf_mem[0] !== 32'hA5A5_0000) begin
      n_fail++;
      $display("FAIL x0 untouched: got %h, want a5a50000", rf_mem[0]);
    end
  endtask

  task automatic test_single_a();
    qa.push_back('{5'd5, 32'hDEAD_BEEF});
    run_stream(0, "single_a");
    n_checks++;
    if (last_src !== 1'b0) begin
      n_fail++;
      $display("FAIL single_a last_src: got %b, want 0", last_src);
    end
  endtask

  task automatic test_x0_b();
    qb.push_back('{5'd0, 32'h0000_1234});
    run_stream(0, "x0_b");
    n_checks++;
    if ({last_src, rf_mem[0]} !== {1'b1, 32'hA5A5_0000}) begin
      n_fail++;
      $display("FAIL x0_b: last=%b x0=%h, want last=1 x0=a5a50000",
               last_src, rf_mem[0]);
    end
  endtask

  task automatic test_back_to_back();
    logic [4:0] want [4];
    want = '{5'd1, 5'd3, 5'd2, 5'd4};
    qa.push_back('{5'd1, 32'hA000_0001});
    qa.push_back('{5'd2, 32'hA000_0002});
    qb.push_back('{5'd3, 32'hB000_0003});
    qb.push_back('{5'd4, 32'hB000_0004});
    run_stream(0, "b2b");
    n_checks++;
    if (grant_log.size() != 4) begin
      n_fail++;
      $display("FAIL b2b count: got %0d grants, want 4", grant_log.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        n_checks++;
        if (grant_log[i] !== want[i]) begin
          n_fail++;
          $display("FAIL b2b order %0d: got x%0d, want x%0d",
                   i, grant_log[i], want[i]);
        end
      end
    end
  endtask

  task automatic test_same_addr();
    qa.push_back('{5'd6, 32'h0000_0066});
    run_stream(0, "same_pre");
    qa.push_back('{5'd7, 32'h0000_0011});
    qb.push_back('{5'd7, 32'h0000_0022});
    run_stream(0, "same_addr");
    n_checks++;
    if (rf_mem[7] !== 32'h0000_0011) begin
      n_fail++;
      $display("FAIL same_addr x7: got %h, want 00000011", rf_mem[7]);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 40; i++) begin
      qa.push_back('{5'($urandom), $urandom});
      qb.push_back('{5'($urandom), $urandom});
    end
    run_stream(30, "random");
  endtask

  task automatic test_reset_mid_sweep();
    idle_inputs();
    reset = 1'b1;
    step();
    reset = 1'b0;
    for (int k = 1; k <= 9; k++) begin
      step();
      n_checks++;
      if ({rf_we, rf_waddr} !== {1'b1, 5'(k)}) begin
        n_fail++;
        $display("FAIL mid_sweep edge %0d: we=%b addr=%0d, want 1 %0d",
                 k, rf_we, rf_waddr, k);
      end
    end
    reset = 1'b1;
    step();
    n_checks++;
    if ({rf_we, rf_waddr, rf_wdata, init_done, last_src}
        !== {1'b0, 5'd0, 32'h0, 1'b0, 1'b1}) begin
      n_fail++;
      $display("FAIL mid_sweep reset: we=%b addr=%0d data=%h done=%b last=%b, want 0 0 0 0 1",
               rf_we, rf_waddr, rf_wdata, init_done, last_src);
    end
    reset = 1'b0;
    sweep_check("resweep");
  endtask

  task automatic test_reset_mid_run();
    qa.push_back('{5'd9, 32'h0000_0099});
    run_stream(0, "run_pre");
    wb.a_valid = 1'b1;
    wb.a_addr  = 5'd9;
    wb.a_data  = 32'hBAD0_0009;
    reset = 1'b1;
    #1;
    n_checks++;
    if (wb.a_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_run ready: a_ready=%b, want 0", wb.a_ready);
    end
    step();
    n_checks++;
    if ({rf_we, init_done, last_src} !== 3'b001) begin
      n_fail++;
      $display("FAIL mid_run reset: we=%b done=%b last=%b, want 0 0 1",
               rf_we, init_done, last_src);
    end
    reset = 1'b0;
    idle_inputs();
    sweep_check("run_resweep");
    n_checks++;
    if (rf_mem[9] !== 32'h0) begin
      n_fail++;
      $display("FAIL mid_run x9: got %h, want 0", rf_mem[9]);
    end
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_single_a();
    test_x0_b();
    test_back_to_back();
    test_same_addr();
    test_random();
    test_reset_mid_sweep();
    test_reset_mid_run();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/rf_wb_arbiter.md
Name: rf_wb_arbiter

Overview:
- Sole driver of the register-file write port (`cu_rdwrite`, `rd_addr`, `rd_in`).
- After reset, a sequencer sweeps x1..x31 to zero, because the register file itself has no reset.
- After the sweep, it arbitrates round-robin between two writeback requesters (A: ALU/single-cycle path, B: multi-cycle unit such as load or divide) using valid/ready handshakes.
- Write-port outputs are registered: one write per cycle, committed by the register file on the following posedge.

Parameters:
- XLEN, 32, data width of write data.
- AW, 5, register address width (32 registers).
- INIT_EN, 1, when 1 run the zero-sweep after reset; when 0 skip it.

Ports:
- clock  input  1  system clock, all state on posedge.
- reset  input  1  synchronous, active-high reset.
- a_valid  input  1  requester A has a write.
- a_addr  input  AW  requester A destination register.
- a_data  input  XLEN  requester A write data.
- a_ready  output  1  A beat accepted this cycle (combinational).
- b_valid  input  1  requester B has a write.
- b_addr  input  AW  requester B destination register.
- b_data  input  XLEN  requester B write data.
- b_ready  output  1  B beat accepted this cycle (combinational).
- rf_we  output  1  registered write enable to the register file.
- rf_waddr  output  AW  registered write address.
- rf_wdata  output  XLEN  registered write data.
- init_done  output  1  high once the sweep is complete and arbitration is live.
- last_src  output  1  source of the most recent accepted beat (0=A, 1=B).

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- Reset (sampled at posedge):
  - Outputs: rf_we=0, rf_waddr=0, rf_wdata=0, init_done=0, last_src=1 (A has priority first).
  - Internal: state=INIT, sweep counter=1.
  - Reset asserted mid-sweep or mid-run aborts everything. Any beat presented but not yet handshaken is not written. The sweep restarts from x1.
- States: INIT, RUN.
- INIT (INIT_EN=1):
  - a_ready=b_ready=0.
  - Each posedge loads rf_we=1, rf_waddr=cnt, rf_wdata=0, then cnt increments.
  - At the edge that loads rf_waddr=31, the next state is RUN.
  - Timing from the first edge with reset low: edges 1..31 present x1..x31. Edge 32 sets init_done=1 and rf_we=0.
  - x0 is never written.
- INIT_EN=0: the first edge with reset low goes to RUN and sets init_done=1; rf_we stays 0.
- RUN, arbitration (combinational ready):
  - Only A valid: a_ready=1.
  - Only B valid: b_ready=1.
  - Both valid: grant the source != last_src. The other source's ready=0 and it must hold valid/addr/data stable.
  - Neither valid: both readies 0.
  - At most one ready high per cycle. Ready never depends on the requester's own ready.
- RUN, on a handshake (valid & ready) at a posedge:
  - rf_waddr <= addr, rf_wdata <= data, rf_we <= (addr != 0), last_src <= granted source.
  - Writes to x0 are consumed (handshake completes, last_src updates) but rf_we=0.
- RUN, no handshake: rf_we <= 0; rf_waddr and rf_wdata hold their values.
- Latency: handshake at edge N; the write is visible on the rf_* outputs after edge N; the register file commits it at edge N+1.
- Throughput and fairness: one write per cycle sustained. With both requesters continuously valid, grants alternate A,B,A,B. No requester waits more than 1 cycle.
- Same-address collision: A and B targeting the same register serialise in grant order. The later grant's data is the final register value.
- No back-pressure from the register file: the write port is always available.

Test Plan:
- Reset held 3 cycles, then released with INIT_EN=1 → rf_we=1 with rf_waddr=1..31 and rf_wdata=0 on edges 1..31; a_ready=b_ready=0 throughout; init_done=1 and rf_we=0 at edge 32; a register-file readback of x1..x31 returns 0.
- RUN, a_valid with a_addr=5 and a_data=0xDEADBEEF for one cycle → a_ready=1; next cycle rf_we=1, rf_waddr=5, rf_wdata=0xDEADBEEF, last_src=0; the cycle after, rf_we=0.
- RUN, A and B both valid for 4 cycles with distinct addresses 1,2 (A) and 3,4 (B) → grant order A,B,A,B; rf_waddr sequence 1,3,2,4; each requester holds its beat until granted.
- RUN, b_valid with b_addr=0 and b_data=0x1234 → b_ready=1, rf_we stays 0, last_src=1; a subsequent contested cycle grants A.
- Same address: A writes x7=0x11 and B writes x7=0x22 simultaneously, with last_src=0 → B granted first, then A; final x7=0x11.
- Reset asserted at sweep edge 10 for 1 cycle → all outputs zeroed; the sweep restarts at rf_waddr=1 and completes 31 edges after release. The same applies with reset mid-RUN: the held A beat is not written and init_done drops to 0.
